// File: rtl/hdmi_video_rx.sv
// rtl/hdmi_video_rx.sv - HDMI parallel video sink: timing measurement, lock FSM, framed pixel stream
module hdmi_video_rx #(
    parameter int DATA_W      = 24,
    parameter int H_CNT_W     = 12,
    parameter int V_CNT_W     = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               vsync_i,
    input  logic               hsync_i,
    input  logic               de_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               pix_valid_o,
    output logic [DATA_W-1:0]  pix_data_o,
    output logic               pix_sof_o,
    output logic               pix_eol_o,
    output logic               locked_o,
    output logic               timing_err_o,
    output logic [H_CNT_W-1:0] h_total_o,
    output logic [H_CNT_W-1:0] h_active_o,
    output logic [V_CNT_W-1:0] v_total_o,
    output logic [V_CNT_W-1:0] v_active_o
);
    typedef enum logic [1:0] {ST_UNLOCKED, ST_CHECK, ST_LOCKED} state_t;

    // Input pipeline: stage 1, stage 2, plus hsync stage 3 for end-of-line on hsync rise
    logic vs1_q, hs1_q, de1_q, vs2_q, hs2_q, de2_q, hs3_q;
    logic [DATA_W-1:0] d1_q, d2_q;

    // Line / frame measurement
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d, a_cnt_q, a_cnt_d, fr_len_q, fr_len_d, fr_act_q, fr_act_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
    logic line_started_q, line_started_d, line_sat_q, line_sat_d;
    logic fr_started_q, fr_started_d, fr_bad_q, fr_bad_d, fr_have_len_q, fr_have_len_d;
    logic v_sat_q, v_sat_d;

    // Values of the frame closing on this cycle (includes a line closing on the same cycle)
    logic line_close, line_bad, cl_bad, cl_have_len, cl_vsat, frame_ok, frame_match;
    logic [H_CNT_W-1:0] cl_len, cl_act;
    logic [V_CNT_W-1:0] cl_vt;

    // Lock FSM and reference
    state_t state_q, state_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [H_CNT_W-1:0] ref_ht_q, ref_ht_d, ref_ha_q, ref_ha_d, h_total_q, h_total_d, h_active_q, h_active_d;
    logic [V_CNT_W-1:0] ref_vt_q, ref_vt_d, ref_va_q, ref_va_d, v_total_q, v_total_d, v_active_q, v_active_d;
    logic locked_q, locked_d, timing_err_q, timing_err_d, drop, wd_trip;

    // Pixel output
    logic fwd_q, fwd_d, sof_pend_q, sof_pend_d;
    logic pv_q, pv_d, psof_q, psof_d, peol_q, peol_d;
    logic [DATA_W-1:0] pd_q, pd_d;

    logic vs_rise, hs_rise, de_rise;

    assign vs_rise = vs1_q & ~vs2_q;
    assign hs_rise = hs1_q & ~hs2_q;
    assign de_rise = de1_q & ~de2_q;

    // Close the current line/frame and advance the line and frame counters
    always_comb begin
        h_cnt_d        = h_cnt_q;
        a_cnt_d        = a_cnt_q;
        line_started_d = line_started_q | hs_rise;
        line_sat_d     = line_sat_q;
        fr_started_d   = fr_started_q;

        line_close  = hs_rise & line_started_q;
        line_bad    = line_sat_q
                    | (fr_have_len_q & (h_cnt_q != fr_len_q))
                    | ((a_cnt_q != '0) & (fr_act_q != '0) & (a_cnt_q != fr_act_q));
        cl_bad      = fr_bad_q | (line_close & line_bad);
        cl_have_len = fr_have_len_q | line_close;
        cl_len      = (line_close & ~fr_have_len_q) ? h_cnt_q : fr_len_q;
        cl_act      = (line_close & (fr_act_q == '0)) ? a_cnt_q : fr_act_q;
        cl_vsat     = v_sat_q | (hs_rise & (v_cnt_q == '1));
        cl_vt       = (hs_rise & (v_cnt_q != '1)) ? v_cnt_q + 1'b1 : v_cnt_q;
        frame_ok    = fr_started_q & ~cl_bad & cl_have_len & ~cl_vsat & (cl_vt != '0);
        frame_match = (cl_len == ref_ht_q) & (cl_act == ref_ha_q)
                    & (cl_vt == ref_vt_q) & (va_cnt_q == ref_va_q);

        if (hs_rise) begin
            h_cnt_d    = H_CNT_W'(1);
            a_cnt_d    = de1_q ? H_CNT_W'(1) : '0;
            line_sat_d = 1'b0;
        end else begin
            if (h_cnt_q != '1) h_cnt_d = h_cnt_q + 1'b1;
            else               line_sat_d = 1'b1;
            if (de1_q && (a_cnt_q != '1)) a_cnt_d = a_cnt_q + 1'b1;
        end

        if (vs_rise) begin
            fr_started_d  = 1'b1;
            fr_bad_d      = 1'b0;
            fr_have_len_d = 1'b0;
            fr_len_d      = '0;
            fr_act_d      = '0;
            v_cnt_d       = '0;
            va_cnt_d      = de_rise ? V_CNT_W'(1) : '0;
            v_sat_d       = 1'b0;
        end else begin
            fr_bad_d      = cl_bad;
            fr_have_len_d = cl_have_len;
            fr_len_d      = cl_len;
            fr_act_d      = cl_act;
            v_cnt_d       = cl_vt;
            v_sat_d       = cl_vsat | (de_rise & (va_cnt_q == '1));
            va_cnt_d      = (de_rise & (va_cnt_q != '1)) ? va_cnt_q + 1'b1 : va_cnt_q;
        end
    end

    // Lock FSM: evaluate the closing frame at each vsync rise; watchdog on missing hsync
    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        ref_ht_d     = ref_ht_q;
        ref_ha_d     = ref_ha_q;
        ref_vt_d     = ref_vt_q;
        ref_va_d     = ref_va_q;
        h_total_d    = h_total_q;
        h_active_d   = h_active_q;
        v_total_d    = v_total_q;
        v_active_d   = v_active_q;
        drop         = 1'b0;
        wd_trip      = (state_q == ST_LOCKED) & line_sat_q & ~hs_rise;

        if (state_q == ST_LOCKED) begin
            if (wd_trip || (vs_rise && !(frame_ok && frame_match))) begin
                state_d     = ST_UNLOCKED;
                match_cnt_d = '0;
                drop        = 1'b1;
            end
        end else if (vs_rise) begin
            if (!frame_ok) begin
                state_d     = ST_UNLOCKED;
                match_cnt_d = '0;
            end else if ((state_q == ST_CHECK) && frame_match) begin
                match_cnt_d = match_cnt_q + 4'd1;
            end else begin
                state_d     = ST_CHECK;
                match_cnt_d = 4'd1;
                ref_ht_d    = cl_len;
                ref_ha_d    = cl_act;
                ref_vt_d    = cl_vt;
                ref_va_d    = va_cnt_q;
            end
            if (frame_ok && (match_cnt_d >= 4'(LOCK_FRAMES))) begin
                state_d    = ST_LOCKED;
                h_total_d  = cl_len;
                h_active_d = cl_act;
                v_total_d  = cl_vt;
                v_active_d = va_cnt_q;
            end
        end

        locked_d     = (state_d == ST_LOCKED);
        timing_err_d = drop;
    end

    // Pixel path: forward stage-2 pixels of frames opened while locked
    always_comb begin
        fwd_d      = fwd_q;
        sof_pend_d = sof_pend_q;
        pv_d       = de2_q & fwd_q & ~drop;
        pd_d       = d2_q;
        psof_d     = pv_d & sof_pend_q;
        peol_d     = pv_d & (~de1_q | (hs2_q & ~hs3_q));
        if (vs_rise) begin
            fwd_d      = (state_d == ST_LOCKED);
            sof_pend_d = (state_d == ST_LOCKED);
        end else if (pv_d) begin
            sof_pend_d = 1'b0;
        end
        if (drop) fwd_d = 1'b0;
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs1_q <= 1'b0; hs1_q <= 1'b0; de1_q <= 1'b0; d1_q <= '0;
            vs2_q <= 1'b0; hs2_q <= 1'b0; de2_q <= 1'b0; d2_q <= '0; hs3_q <= 1'b0;
            h_cnt_q <= '0; a_cnt_q <= '0; line_started_q <= 1'b0; line_sat_q <= 1'b0;
            fr_started_q <= 1'b0; fr_bad_q <= 1'b0; fr_have_len_q <= 1'b0;
            fr_len_q <= '0; fr_act_q <= '0; v_cnt_q <= '0; va_cnt_q <= '0; v_sat_q <= 1'b0;
            state_q <= ST_UNLOCKED; match_cnt_q <= '0;
            ref_ht_q <= '0; ref_ha_q <= '0; ref_vt_q <= '0; ref_va_q <= '0;
            h_total_q <= '0; h_active_q <= '0; v_total_q <= '0; v_active_q <= '0;
            locked_q <= 1'b0; timing_err_q <= 1'b0;
            fwd_q <= 1'b0; sof_pend_q <= 1'b0;
            pv_q <= 1'b0; pd_q <= '0; psof_q <= 1'b0; peol_q <= 1'b0;
        end else begin
            vs1_q <= vsync_i; hs1_q <= hsync_i; de1_q <= de_i; d1_q <= data_i;
            vs2_q <= vs1_q; hs2_q <= hs1_q; de2_q <= de1_q; d2_q <= d1_q; hs3_q <= hs2_q;
            h_cnt_q <= h_cnt_d; a_cnt_q <= a_cnt_d;
            line_started_q <= line_started_d; line_sat_q <= line_sat_d;
            fr_started_q <= fr_started_d; fr_bad_q <= fr_bad_d; fr_have_len_q <= fr_have_len_d;
            fr_len_q <= fr_len_d; fr_act_q <= fr_act_d; v_cnt_q <= v_cnt_d; va_cnt_q <= va_cnt_d;
            v_sat_q <= v_sat_d;
            state_q <= state_d; match_cnt_q <= match_cnt_d;
            ref_ht_q <= ref_ht_d; ref_ha_q <= ref_ha_d; ref_vt_q <= ref_vt_d; ref_va_q <= ref_va_d;
            h_total_q <= h_total_d; h_active_q <= h_active_d;
            v_total_q <= v_total_d; v_active_q <= v_active_d;
            locked_q <= locked_d; timing_err_q <= timing_err_d;
            fwd_q <= fwd_d; sof_pend_q <= sof_pend_d;
            pv_q <= pv_d; pd_q <= pd_d; psof_q <= psof_d; peol_q <= peol_d;
        end
    end

    assign pix_valid_o  = pv_q;
    assign pix_data_o   = pd_q;
    assign pix_sof_o    = psof_q;
    assign pix_eol_o    = peol_q;
    assign locked_o     = locked_q;
    assign timing_err_o = timing_err_q;
    assign h_total_o    = h_total_q;
    assign h_active_o   = h_active_q;
    assign v_total_o    = v_total_q;
    assign v_active_o   = v_active_q;
endmodule

// File: tb/tb_hdmi_video_rx.sv
// tb/tb_hdmi_video_rx.sv - directed bench for hdmi_video_rx lock, pixel framing, watchdog and reset
module tb_hdmi_video_rx;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        vsync_i = 1'b0, hsync_i = 1'b0, de_i = 1'b0;
    logic [23:0] data_i = '0;
    logic        pix_valid_o, pix_sof_o, pix_eol_o, locked_o, timing_err_o;
    logic [23:0] pix_data_o;
    logic [11:0] h_total_o, h_active_o;
    logic [10:0] v_total_o, v_active_o;

    hdmi_video_rx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .vsync_i(vsync_i), .hsync_i(hsync_i), .de_i(de_i), .data_i(data_i),
        .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o),
        .pix_sof_o(pix_sof_o), .pix_eol_o(pix_eol_o),
        .locked_o(locked_o), .timing_err_o(timing_err_o),
        .h_total_o(h_total_o), .h_active_o(h_active_o),
        .v_total_o(v_total_o), .v_active_o(v_active_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int in_cyc [256];
    int n_valid, n_sof, n_eol, n_err, n_lat_bad;
    logic [23:0] sof_data, last_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_sof = 0; n_eol = 0; n_err = 0; n_lat_bad = 0;
        sof_data = 24'hffffff; last_data = 24'hffffff;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {59'd0, pix_valid_o, pix_sof_o, pix_eol_o, locked_o, timing_err_o}, 64'd0);
        check({tag, "_data"}, {40'd0, pix_data_o}, 64'd0);
        check({tag, "_meas"}, {18'd0, h_total_o, h_active_o, v_total_o, v_active_o}, 64'd0);
    endtask

    task automatic check_meas(input string tag, input int ht, input int ha, input int vt, input int va);
        check({tag, "_h_total"},  {52'd0, h_total_o},  64'(ht));
        check({tag, "_h_active"}, {52'd0, h_active_o}, 64'(ha));
        check({tag, "_v_total"},  {53'd0, v_total_o},  64'(vt));
        check({tag, "_v_active"}, {53'd0, v_active_o}, 64'(va));
    endtask

    // One clock: sample outputs just after the edge, then drive the next inputs
    task automatic step(input logic vs, input logic hs, input logic de, input logic [23:0] d);
        @(posedge clk_i);
        cyc++;
        #1;
        if (pix_valid_o === 1'b1) begin
            n_valid++;
            last_data = pix_data_o;
            if (cyc - in_cyc[pix_data_o[7:0]] != 3) n_lat_bad++;
        end
        if (pix_sof_o === 1'b1) begin
            n_sof++;
            sof_data = pix_data_o;
        end
        if (pix_eol_o === 1'b1)    n_eol++;
        if (timing_err_o === 1'b1) n_err++;
        vsync_i = vs;
        hsync_i = hs;
        de_i    = de;
        data_i  = de ? d : 24'h0;
        if (de) in_cyc[d[7:0]] = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    // vsync 2 lines and hsync 4 clocks at the start of each frame/line
    task automatic run_frame(input int ht, input int ha0, input int ha, input int vt,
                             input int va0, input int va, input int stretch, input int max_cyc);
        int n;
        logic [23:0] d;
        logic de;
        n = 0;
        d = '0;
        clear_stats();
        for (int l = 0; l < vt; l++) begin
            for (int x = 0; x < ht + ((l == stretch) ? 1 : 0); x++) begin
                if (n == max_cyc) return;
                de = (l >= va0) && (l < va0 + va) && (x >= ha0) && (x < ha0 + ha);
                step(l < 2, x < 4, de, d);
                if (de) d = d + 24'd1;
                n++;
            end
        end
    endtask

    task automatic frame_a(input int stretch);
        run_frame(20, 6, 12, 10, 3, 6, stretch, -1);
    endtask

    task automatic frame_b(input int max_cyc);
        run_frame(30, 8, 16, 12, 3, 8, -1, max_cyc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) in_cyc[i] = -100;
        clear_stats();
        rst_i = 1'b1;
        idle(4);
        check_zero("reset");
        rst_i = 1'b0;
        idle(5);

        frame_a(-1);
        check("f1_locked", {63'd0, locked_o}, 64'd0);
        frame_a(-1);
        check("f2_locked", {63'd0, locked_o}, 64'd0);
        frame_a(-1);
        check("f3_locked", {63'd0, locked_o}, 64'd1);
        check_meas("f3", 20, 12, 10, 6);

        frame_a(-1);
        check("f4_valid", 64'(n_valid), 64'd72);
        check("f4_sof", 64'(n_sof), 64'd1);
        check("f4_sof_data", {40'd0, sof_data}, 64'h0);
        check("f4_eol", 64'(n_eol), 64'd6);
        check("f4_last", {40'd0, last_data}, 64'h47);
        check("f4_latency", 64'(n_lat_bad), 64'd0);
        check("f4_err", 64'(n_err), 64'd0);

        frame_a(5);
        check("f5_locked", {63'd0, locked_o}, 64'd1);
        check("f5_err", 64'(n_err), 64'd0);
        frame_a(-1);
        check("f6_err", 64'(n_err), 64'd1);
        check("f6_locked", {63'd0, locked_o}, 64'd0);
        check("f6_valid", 64'(n_valid), 64'd0);
        check("f6_h_total", {52'd0, h_total_o}, 64'd20);
        frame_a(-1);
        check("f7_locked", {63'd0, locked_o}, 64'd0);
        frame_a(-1);
        check("f8_locked", {63'd0, locked_o}, 64'd1);

        clear_stats();
        idle(4200);
        check("wd_err", 64'(n_err), 64'd1);
        check("wd_locked", {63'd0, locked_o}, 64'd0);
        check_meas("wd", 20, 12, 10, 6);

        frame_a(-1);
        frame_a(-1);
        frame_a(-1);
        check("relock_locked", {63'd0, locked_o}, 64'd1);

        frame_b(-1);
        check("n1_locked", {63'd0, locked_o}, 64'd1);
        check("n1_err", 64'(n_err), 64'd0);
        frame_b(-1);
        check("n2_err", 64'(n_err), 64'd1);
        check("n2_locked", {63'd0, locked_o}, 64'd0);
        check("n2_valid", 64'(n_valid), 64'd0);
        check("n2_h_total", {52'd0, h_total_o}, 64'd20);
        frame_b(-1);
        check("n3_locked", {63'd0, locked_o}, 64'd0);
        check("n3_valid", 64'(n_valid), 64'd0);
        frame_b(-1);
        check("n4_locked", {63'd0, locked_o}, 64'd1);
        check_meas("n4", 30, 16, 12, 8);
        check("n4_valid", 64'(n_valid), 64'd128);
        check("n4_sof", 64'(n_sof), 64'd1);
        check("n4_eol", 64'(n_eol), 64'd8);
        check("n4_last", {40'd0, last_data}, 64'h7f);
        check("n4_latency", 64'(n_lat_bad), 64'd0);

        frame_b(102);
        check("mid_valid", {63'd0, pix_valid_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        check_zero("mid_reset");
        idle(3);
        rst_i = 1'b0;
        idle(5);
        frame_b(-1);
        frame_b(-1);
        check("r2_locked", {63'd0, locked_o}, 64'd0);
        frame_b(-1);
        check("r3_locked", {63'd0, locked_o}, 64'd1);
        check_meas("r3", 30, 16, 12, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_video_rx.md
Name: hdmi_video_rx

Overview:
Sink-side counterpart of the team's HDMI timing/pixel generator. It accepts parallel video (active-high vsync/hsync, de, 24-bit RGB), measures line and frame timing, and declares lock after consecutive identical frames. Once locked, it emits a framed pixel stream with start-of-frame and end-of-line markers for downstream consumers such as checkers and frame buffers.

Parameters:
DATA_W, 24, pixel width (R[23:16], G[15:8], B[7:0])
H_CNT_W, 12, width of horizontal cycle counters
V_CNT_W, 11, width of line counters
LOCK_FRAMES, 2, consecutive matching frames required to assert lock (1..15)

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  reset
vsync_i  in  1  vertical sync, active high
hsync_i  in  1  horizontal sync, active high
de_i  in  1  data enable
data_i  in  DATA_W  pixel data, valid when de_i=1
pix_valid_o  out  1  output pixel valid
pix_data_o  out  DATA_W  output pixel
pix_sof_o  out  1  first pixel of frame
pix_eol_o  out  1  last pixel of line
locked_o  out  1  timing locked
timing_err_o  out  1  one-cycle pulse on loss of lock
h_total_o  out  H_CNT_W  clocks per line
h_active_o  out  H_CNT_W  de clocks per line
v_total_o  out  V_CNT_W  lines per frame
v_active_o  out  V_CNT_W  lines containing de

Behaviour:
- Reset rst_i, asynchronous, active-high; clock clk_i. All outputs are 0 on reset; FSM enters UNLOCKED; all counters clear.
- Stage 1 registers all inputs. Edge detection (rise/fall of vsync, hsync, de) uses stage 1 against stage 2.
- Line length: the number of clk cycles between consecutive hsync rises. The counter saturates at all-ones; a saturated line is invalid.
- Line active width: the number of de-high cycles between hsync rises.
- Frame: the interval between consecutive vsync rises. v_total is the hsync rises counted in the frame. v_active is the de rises counted in the frame.
- Frame is valid when all of the following hold:
  - it starts after a vsync rise, so the first partial frame after reset is invalid;
  - every complete line has the same length and the same non-zero active width, or zero active width for blanking lines;
  - no counter saturates;
  - v_total >= 1.
- FSM is evaluated at each vsync rise, on the measurements of the frame just ended:
  - UNLOCKED: a valid frame stores the reference measurements, sets match_cnt=1 and moves to CHECK. Otherwise it stays in UNLOCKED.
  - CHECK: a valid frame equal to the reference increments match_cnt. When match_cnt reaches LOCK_FRAMES, go to LOCKED, set locked_o=1 and load the h/v outputs. A mismatching valid frame becomes the new reference with match_cnt=1. An invalid frame goes to UNLOCKED.
  - LOCKED: a valid, matching frame stays in LOCKED. Otherwise go to UNLOCKED, clear locked_o and pulse timing_err_o for exactly one cycle. The h/v outputs hold their last locked values.
  - Watchdog: while LOCKED, if no hsync rise occurs for 2^H_CNT_W cycles, the block drops lock immediately with the same actions as above.
- Measurement outputs change only on entry to LOCKED.
- Pixel path:
  - Latency is 3 clocks: an input pixel on cycle N appears on the outputs at N+3.
  - A frame is forwarded only if locked_o=1 just after the vsync rise that opens it. Loss of lock during a forwarded frame stops pix_valid_o from the next cycle.
  - pix_valid_o follows de exactly within forwarded frames. pix_data_o is don't-care when pix_valid_o=0.
  - pix_sof_o is set on the first valid pixel of a forwarded frame only.
  - pix_eol_o is set on the pixel whose de falls on the next input cycle, or on which hsync rises.
  - A line of 1 pixel asserts both pix_sof_o and pix_eol_o where applicable.
- Simultaneous events:
  - vsync rise and hsync rise on the same cycle: the line closes before the frame closes, so the line counts toward the ending frame.
  - de high during vsync rise: the pixel belongs to the new frame.
- rst_i asserted mid-frame aborts everything. The first frame after release is invalid.

Test Plan:
1. Generator timing (H total 20, hsync 4, active 12; V total 10, vsync 2, active 6), LOCK_FRAMES=2 -> locked_o rises at the 3rd vsync rise. Outputs read h_total 20, h_active 12, v_total 10, v_active 6.
2. Locked; stream incrementing RGB from 0x000000 -> frame carries exactly 72 pix_valid_o, one pix_sof_o with data 0x000000, and 6 pix_eol_o. The last pixel is 0x000047. Each valid output occurs 3 clocks after its input.
3. Locked; one line of one frame stretched to 21 clocks -> at that frame's vsync rise locked_o=0 and timing_err_o is high for one cycle. Lock returns after 2 further clean frames.
4. Locked; hsync stuck low for 4096 cycles -> lock drops with a timing_err_o pulse before the next vsync. Measurements keep 20/12/10/6.
5. Resolution change to H 30/active 16, V 12/active 8 after lock -> error pulse, then re-lock with the new values after 2 frames. No pixels are forwarded in the unlocked frames.
6. rst_i pulsed mid-frame while locked -> all outputs 0 immediately. Lock is reacquired only at the 3rd vsync rise after release.
